// File: rtl/iddmm_final_sel.sv
// iddmm_final_sel
// Final-reduction selector for the word-serial IDDMM datapath.
// It collects N words of the unreduced operand A and N words of A-B, plus the
// final borrow that arrives with word N-1. It then streams out A (when the
// borrow is set, meaning A<B) or A-B (otherwise), word-serially, LSW first.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        input word handshake (ready only while collecting)
//   in_addr                  expected word index (mismatch -> seq_err)
//   in_a, in_diff            operand word and subtractor result word
//   in_borrow                final borrow, sampled with word N-1 only
//   out_valid/out_ready      output word handshake
//   out_addr, out_data       index and value of the selected result word
//   out_last                 marks word N-1
//   sel_a                    1 = result is A, 0 = result is A-B
//   seq_err                  sticky in_addr mismatch flag, cleared by rst
//
// state   | meaning
// COLLECT | accepting input words into buf_a/buf_d
// OUTPUT  | streaming the selected buffer to the next stage
module iddmm_final_sel #(
   parameter int W      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [W-1:0]      in_a,
   input  logic [W-1:0]      in_diff,
   input  logic              in_borrow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [W-1:0]      out_data,
   output logic              out_last,
   output logic              sel_a,
   output logic              seq_err
);

   typedef enum logic {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   state_t            state, state_nxt;
   logic [W-1:0]      buf_a [N];
   logic [W-1:0]      buf_d [N];
   logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_nxt;
   logic              accept, out_hs, wr_last;
   logic [W-1:0]      head_a, head_d;
   logic              out_valid_d, out_last_d, sel_a_d;
   logic [W-1:0]      out_data_d;

   // in_ready is decoded from the state register only; out_ready never reaches it.
   assign in_ready = (state == COLLECT) && !rst;
   assign accept   = in_valid && (state == COLLECT);
   assign wr_last  = (wr_cnt == LAST);
   assign out_hs   = out_valid && out_ready;
   assign rd_nxt   = rd_cnt + 1'b1;
   assign out_addr = rd_cnt;

   // Word 0 for the first output cycle. With N=1 it is the word being accepted
   // at this very edge and is not in the buffer yet, so take it from the inputs.
   assign head_a = (N == 1) ? in_a    : buf_a[0];
   assign head_d = (N == 1) ? in_diff : buf_d[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && wr_last)  state_nxt = OUTPUT;
         OUTPUT:  if (out_hs && out_last) state_nxt = COLLECT;
         default:                         state_nxt = COLLECT;
      endcase
   end

   // Next values of the registered outputs; they change only on the edge that
   // enters OUTPUT or on an output handshake, so backpressure holds them.
   always_comb begin
      out_valid_d = out_valid;
      out_last_d  = out_last;
      sel_a_d     = sel_a;
      out_data_d  = out_data;
      case (state)
         COLLECT: begin
            if (accept && wr_last) begin
               sel_a_d     = in_borrow;
               out_valid_d = 1'b1;
               out_last_d  = (N == 1);
               out_data_d  = in_borrow ? head_a : head_d;
            end
         end
         OUTPUT: begin
            if (out_hs) begin
               if (out_last) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  out_last_d = (rd_nxt == LAST);
                  out_data_d = sel_a ? buf_a[rd_nxt] : buf_d[rd_nxt];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         sel_a     <= 1'b0;
         out_data  <= '0;
         seq_err   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
      end else begin
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
         sel_a     <= sel_a_d;
         out_data  <= out_data_d;
         if (accept) begin
            // A misaddressed word is still stored at wr_cnt; only the flag records it.
            if (in_addr != wr_cnt) seq_err <= 1'b1;
            if (wr_last) begin
               wr_cnt <= '0;
               rd_cnt <= '0;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         if (state == OUTPUT && out_hs) begin
            if (out_last) rd_cnt <= '0;
            else          rd_cnt <= rd_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_a[wr_cnt] <= in_a;
         buf_d[wr_cnt] <= in_diff;
      end
   end

endmodule

// File: tb/tb_iddmm_final_sel.sv
module tb_iddmm_final_sel;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_diff;
   logic          in_borrow;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          sel_a;
   logic          seq_err;

   iddmm_final_sel #(.W(W), .N(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_a(in_a), .in_diff(in_diff), .in_borrow(in_borrow),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .sel_a(sel_a), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // Operand words are gathered in arrays; once N words are in, the result is
   // chosen as a whole (borrow ? A : A-B) and then walked through by index.
   logic [W-1:0] mdl_a [N];
   logic [W-1:0] mdl_d [N];
   logic [W-1:0] mdl_exp [N];
   int           mdl_cnt = 0;
   int           mdl_idx = 0;
   bit           mdl_out = 0;
   bit           mdl_sel = 0;
   bit           mdl_err = 0;
   logic [W-1:0] got_q [$];

   // Inputs change 2 time units after the rising edge, so at the falling edge
   // everything is stable and reflects what the next rising edge will see.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready",  64'(in_ready),  64'(0));
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_out_addr",  64'(out_addr),  64'(0));
         chk("rst_out_data",  64'(out_data),  64'(0));
         chk("rst_out_last",  64'(out_last),  64'(0));
         chk("rst_sel_a",     64'(sel_a),     64'(0));
         chk("rst_seq_err",   64'(seq_err),   64'(0));
         mdl_out = 0; mdl_cnt = 0; mdl_idx = 0; mdl_sel = 0; mdl_err = 0;
      end else begin
         chk("in_ready",  64'(in_ready),  64'(!mdl_out));
         chk("out_valid", 64'(out_valid), 64'(mdl_out));
         chk("seq_err",   64'(seq_err),   64'(mdl_err));
         if (mdl_out) begin
            chk("out_addr", 64'(out_addr), 64'(mdl_idx));
            chk("out_data", 64'(out_data), 64'(mdl_exp[mdl_idx]));
            chk("out_last", 64'(out_last), 64'(mdl_idx == N - 1));
            chk("sel_a",    64'(sel_a),    64'(mdl_sel));
         end
         if (!mdl_out && in_valid) begin
            if (int'(in_addr) != mdl_cnt) mdl_err = 1;
            mdl_a[mdl_cnt] = in_a;
            mdl_d[mdl_cnt] = in_diff;
            if (mdl_cnt == N - 1) begin
               mdl_sel = in_borrow;
               for (int i = 0; i < N; i++) mdl_exp[i] = in_borrow ? mdl_a[i] : mdl_d[i];
               mdl_out = 1;
               mdl_idx = 0;
               mdl_cnt = 0;
            end else begin
               mdl_cnt++;
            end
         end else if (mdl_out && out_ready) begin
            got_q.push_back(out_data);
            if (mdl_idx == N - 1) mdl_out = 0;
            else                  mdl_idx++;
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0][W-1:0]  a;
      logic [N-1:0][W-1:0]  d;
      logic [N-1:0][AW-1:0] addr;
      logic [N-1:0]         brw;
      logic [6:0]           rdy;     // out_ready pattern, bit 0 first, repeating
      bit                   junk;    // keep in_valid high with junk data during output
      bit                   exp_sel;
      logic [N-1:0][W-1:0]  exp;
      bit                   exp_err;
   } vec_t;

   localparam int NV = 7;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic [W-1:0] abase, input logic [W-1:0] dbase,
                               input logic [N-1:0][AW-1:0] addr, input logic [N-1:0] brw,
                               input logic [6:0] rdy, input bit junk,
                               input bit exp_sel, input bit exp_err);
      vec_t v;
      for (int i = 0; i < N; i++) begin
         v.a[i] = abase + W'(i);
         v.d[i] = dbase + W'(i);
         v.exp[i] = exp_sel ? v.a[i] : v.d[i];
      end
      v.addr = addr; v.brw = brw; v.rdy = rdy; v.junk = junk;
      v.exp_sel = exp_sel; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input vec_t v);
      for (int i = 0; i < N; i++) begin
         in_valid  = 1'b1;
         in_addr   = v.addr[i];
         in_a      = v.a[i];
         in_diff   = v.d[i];
         in_borrow = v.brw[i];
         step();
      end
      in_valid  = v.junk;
      in_addr   = '0;
      in_a      = 32'hDEAD_0000;
      in_diff   = 32'hBAD0_0000;
      in_borrow = 1'b1;
   endtask

   task automatic drain(input logic [6:0] pat, input bit rnd);
      int cyc = 0;
      while (got_q.size() < N && cyc < 200) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 7];
         step();
         cyc++;
      end
      if (got_q.size() < N) chk("drain_timeout", 64'(got_q.size()), 64'(N));
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t v;
      int   cyc;

      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_a = '0; in_diff = '0;
      in_borrow = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      #1 chk("in_ready_after_release", 64'(in_ready), 64'(1));

      tbl[0] = mk(32'hA0, 32'h10, {2'd3,2'd2,2'd1,2'd0}, 4'b0000, 7'h7F, 0, 0, 0);
      tbl[1] = mk(32'hA0, 32'h10, {2'd3,2'd2,2'd1,2'd0}, 4'b1000, 7'h7F, 0, 1, 0);
      tbl[2] = mk(32'hA0, 32'h10, {2'd3,2'd2,2'd1,2'd0}, 4'b0111, 7'b1011001, 0, 0, 0);
      tbl[3] = mk(32'hB0, 32'h20, {2'd3,2'd2,2'd1,2'd0}, 4'b1000, 7'h7F, 1, 1, 0);
      tbl[4] = mk(32'hC0, 32'h30, {2'd3,2'd2,2'd1,2'd0}, 4'b0000, 7'b0110101, 0, 0, 0);
      tbl[5] = mk(32'hD0, 32'h40, {2'd3,2'd2,2'd2,2'd0}, 4'b0000, 7'h7F, 0, 0, 1);
      tbl[6] = mk(32'hE0, 32'h50, {2'd3,2'd2,2'd1,2'd0}, 4'b1000, 7'b1011001, 0, 1, 1);

      step();
      for (int k = 0; k < NV; k++) begin
         got_q.delete();
         send(tbl[k]);
         chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(1));
         chk($sformatf("tbl%0d_sel", k), 64'(sel_a), 64'(tbl[k].exp_sel));
         drain(tbl[k].rdy, 0);
         for (int i = 0; i < N; i++)
            if (i < got_q.size())
               chk($sformatf("tbl%0d_word%0d", k, i), 64'(got_q[i]), 64'(tbl[k].exp[i]));
         chk($sformatf("tbl%0d_seq_err", k), 64'(seq_err), 64'(tbl[k].exp_err));
      end

      // rst clears the sticky sequence error
      rst = 1'b1;
      step();
      chk("seq_err_cleared", 64'(seq_err), 64'(0));
      rst = 1'b0;
      step();

      // rst after two of four words: partial operand discarded
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_addr = AW'(i); in_a = 32'hF0 + W'(i);
         in_diff = 32'h70 + W'(i); in_borrow = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      got_q.delete();
      send(tbl[0]);
      drain(7'h7F, 0);
      for (int i = 0; i < N; i++)
         if (i < got_q.size())
            chk($sformatf("fresh_word%0d", i), 64'(got_q[i]), 64'(32'h10 + i));

      // rst in the middle of OUTPUT: out_valid drops without waiting for an edge
      got_q.delete();
      send(tbl[1]);
      out_ready = 1'b1;
      cyc = 0;
      while (got_q.size() < 2 && cyc < 50) begin step(); cyc++; end
      out_ready = 1'b0;
      chk("mid_out_valid_before_rst", 64'(out_valid), 64'(1));
      rst = 1'b1;
      #1 chk("async_rst_out_valid", 64'(out_valid), 64'(0));
      step();
      rst = 1'b0;
      #1 chk("in_ready_after_mid_rst", 64'(in_ready), 64'(1));
      step();

      // randomized operands with input gaps, random backpressure and rare bad addresses
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) begin
            v.a[i]    = $urandom;
            v.d[i]    = $urandom;
            v.addr[i] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'(i);
            v.brw[i]  = 1'($urandom_range(0, 1));
         end
         got_q.delete();
         for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; step(); end
            in_valid = 1'b1; in_addr = v.addr[i]; in_a = v.a[i];
            in_diff = v.d[i]; in_borrow = v.brw[i];
            step();
         end
         in_valid = 1'($urandom_range(0, 1));
         in_addr = '0; in_a = $urandom; in_diff = $urandom; in_borrow = 1'b0;
         drain(7'h00, 1);
         in_valid = 1'b0;
         for (int i = 0; i < N; i++)
            if (i < got_q.size())
               chk($sformatf("rnd%0d_word%0d", r, i), 64'(got_q[i]),
                   64'(v.brw[N-1] ? v.a[i] : v.d[i]));
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
